bist_ora_misr: RTL and testbench
================================

# bist_ora_misr

Parametrised multiple-input signature register (MISR) output response analyser for the BIST flow. It compacts a CHANNELS-wide response stream into a WIDTH-bit signature using a configurable feedback polynomial, and counts compacted patterns. After NUM_PATTERNS responses it compares the signature against a golden value and reports pass/fail. It sits between the circuit-under-test outputs and the BIST controller, replacing the fixed 3-bit single-input analyser.

## Interface

**Parameters**
- WIDTH, 8: signature width; at least 2.
- CHANNELS, 1: response inputs folded per cycle; 1 ≤ CHANNELS ≤ WIDTH.
- POLY, 8'h1D: feedback taps, excluding the implicit x^WIDTH term. Bit i set means MSB feedback enters bit i. WIDTH=3 with POLY=3'b011 gives the legacy 3-bit analyser.
- NUM_PATTERNS, 16: responses to compact before the check; at least 1.

**Ports**
- clk, input, 1: sole clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- init, input, 1: load seed, clear counter, start a run.
- en, input, 1: the resp value this cycle is valid and is compacted.
- resp, input, CHANNELS: response bits from the CUT.
- seed, input, WIDTH: initial signature, sampled when init=1.
- golden, input, WIDTH: expected final signature, sampled in CHECK.
- sig, output, WIDTH: current signature register.
- busy, output, 1: high in COMPACT and CHECK.
- done, output, 1: high in DONE.
- pass, output, 1: registered result, sig equals golden.
- fail, output, 1: registered result, sig differs from golden.

## Operation

**States.** IDLE, COMPACT, CHECK, DONE.

**Reset (rst=1).** The following values apply on the next edge, and rst overrides everything:
- state = IDLE
- sig = 0
- count = 0
- done = pass = fail = 0

**init=1, any state except under rst.**
- sig ← seed, count ← 0, pass ← 0, fail ← 0, state ← COMPACT.
- init has priority over en in the same cycle; that cycle's resp is not compacted.

**COMPACT with en=1.** Each bit updates as follows:
- sig[i] ← (i>0 ? sig[i-1] : 0) ^ (POLY[i] & sig[WIDTH-1]) ^ (i<CHANNELS ? resp[i] : 0)
- count increments by 1.
- If count == NUM_PATTERNS-1 (the last response), state ← CHECK.

**COMPACT with en=0.** sig and count hold.

**CHECK (one cycle).**
- pass ← (sig == golden), fail ← ~(sig == golden), state ← DONE.

**DONE.**
- sig, pass and fail hold; en is ignored.
- Only init or rst leaves this state.

**IDLE.** en is ignored; sig holds.

**Invariants.**
- pass and fail are never both 1.
- Both are 0 outside DONE, except that they hold their previous values in IDLE after a reset-free return (which cannot occur; IDLE is reached only via rst).
- count width is $clog2(NUM_PATTERNS+1); count never wraps.

## Timing

- Single clock domain; all outputs are registered with no combinational path from inputs.
- Signature latency: the response presented with en in cycle k is reflected in sig from cycle k+1.
- Check latency: the last en in cycle k puts busy in CHECK during k+1. done, pass and fail are valid from k+2.
- Mid-run init: restarts at the next edge and the partial signature is discarded.
- Mid-run rst: returns to IDLE at the next edge with all outputs 0.
- With NUM_PATTERNS=1, the first en goes directly to CHECK.

## Structure

- **Package bist_pkg** holds:
  - the ora_state_t enum (IDLE, COMPACT, CHECK, DONE);
  - the default POLY constant;
  - a pure function misr_next(sig, resp, poly) implementing the per-bit update above.
- **Sub-module misr_core** is the combinational next-signature logic, parametrised by WIDTH, CHANNELS and POLY.
- **Top level** holds the FSM, counter, signature register and compare registers.

## Test plan

1. **Legacy equivalence.** WIDTH=3, POLY=3'b011, CHANNELS=1, NUM_PATTERNS=3, seed=000, golden=101.
   - Stimulus: init, then en with resp 1,0,1.
   - Required: sig goes 001, 010, 101; CHECK, then done=1, pass=1, fail=0.
2. **Feedback path.** Same configuration, seed=100.
   - Stimulus: one en with resp=0.
   - Required: sig=011.
   - Then golden=000 after completing 3 patterns gives fail=1.
3. **Stall and priority.** WIDTH=8 default configuration.
   - Stimulus: en gaps mid-run, then init and en asserted together.
   - Required: sig and count hold during gaps; the simultaneous cycle loads seed and does not compact resp.
4. **Multi-channel.** WIDTH=8, CHANNELS=4, POLY=8'h1D, seed=00.
   - Stimulus: one en with resp=4'hF.
   - Required: sig=8'h0F.
   - A second en with resp=0 gives sig=8'h1E.
5. **Reset mid-run and after DONE.**
   - Stimulus: rst asserted during COMPACT and again during DONE.
   - Required: next cycle shows sig=0, state IDLE, busy=done=pass=fail=0; en is then ignored until init.
6. **NUM_PATTERNS=1.**
   - Stimulus: init, then a single en.
   - Required: busy for 2 cycles, done at k+2, pass/fail matching the one-step signature.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST output response analyser.
// Holds the analyser state encoding, the default feedback taps and the
// pure next-signature function used by the combinational MISR core.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } ora_state_t;

  // x^8 + x^4 + x^3 + x^2 + 1, implicit x^8 term excluded.
  localparam logic [7:0] DEFAULT_POLY = 8'h1D;

  // Widest signature the helper function supports; callers zero-extend.
  localparam int MISR_MAX_W = 64;

  // One MISR step: shift left, fold MSB back through the taps, then XOR in
  // the response channels. Only the low 'width' bits are meaningful.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] resp,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    width,
    input int                    channels
  );
    logic [MISR_MAX_W-1:0] wmask;
    logic [MISR_MAX_W-1:0] cmask;
    logic [MISR_MAX_W-1:0] fb;
    wmask = '0;
    cmask = '0;
    for (int i = 0; i < MISR_MAX_W; i++) begin
      if (i < width)    wmask[i] = 1'b1;
      if (i < channels) cmask[i] = 1'b1;
    end
    // wmask & ~(wmask >> 1) isolates bit width-1, i.e. the signature MSB.
    fb = {MISR_MAX_W{|(sig & wmask & ~(wmask >> 1))}};
    return ((sig << 1) ^ (poly & fb) ^ (resp & cmask)) & wmask;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Combinational next-signature logic for the MISR.
// Ports: sig (current signature), resp (response channels), sig_next.
// Purely combinational; no state, no handshake.
module misr_core
  import bist_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter int              CHANNELS = 1,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(DEFAULT_POLY)
) (
  input  logic [WIDTH-1:0]    sig,
  input  logic [CHANNELS-1:0] resp,
  output logic [WIDTH-1:0]    sig_next
);

  logic [MISR_MAX_W-1:0] full;

  assign full = misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(resp),
                          MISR_MAX_W'(POLY), WIDTH, CHANNELS);
  assign sig_next = full[WIDTH-1:0];

  // Upper bits are always zero from the helper; fold them so they are consumed.
  generate
    if (WIDTH < MISR_MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = |full[MISR_MAX_W-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/bist_ora_misr.sv
// MISR output response analyser: compacts NUM_PATTERNS responses, then checks.
// Ports: clk/rst, init (start run), en+resp (response), seed, golden,
//        sig, busy, done, pass, fail. All outputs are registered state.
module bist_ora_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               CHANNELS     = 1,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(DEFAULT_POLY),
  parameter int               NUM_PATTERNS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                en,
  input  logic [CHANNELS-1:0] resp,
  input  logic [WIDTH-1:0]    seed,
  input  logic [WIDTH-1:0]    golden,
  output logic [WIDTH-1:0]    sig,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail
);

  // Counter holds up to NUM_PATTERNS so it never wraps.
  localparam int              CW   = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0]   LAST = CW'(NUM_PATTERNS - 1);

  ora_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sig_next;

  misr_core #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .POLY     (POLY)
  ) u_core (
    .sig      (sig),
    .resp     (resp),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sig   <= '0;
      count <= '0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else if (init) begin
      // init wins over en: this cycle's resp is deliberately dropped.
      state <= COMPACT;
      sig   <= seed;
      count <= '0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      case (state)
        COMPACT: begin
          if (en) begin
            sig   <= sig_next;
            count <= count + CW'(1);
            if (count == LAST) state <= CHECK;
          end
        end
        CHECK: begin
          pass  <= (sig == golden);
          fail  <= (sig != golden);
          state <= DONE;
        end
        default: begin
          // IDLE and DONE hold everything until init or rst.
        end
      endcase
    end
  end

  assign busy = (state == COMPACT) || (state == CHECK);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bist_ora_misr.sv
module tb_bist_ora_misr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Four configurations: legacy 3-bit, default 8-bit, 4-channel, single pattern.
  localparam int        NDUT = 4;
  localparam int        W_P  [NDUT] = '{3, 8, 8, 8};
  localparam int        CH_P [NDUT] = '{1, 1, 4, 1};
  localparam int        NP_P [NDUT] = '{3, 16, 16, 1};
  localparam logic [7:0] PL_P [NDUT] = '{8'h03, 8'h1D, 8'h1D, 8'h1D};

  logic       rst_v    [NDUT];
  logic       init_v   [NDUT];
  logic       en_v     [NDUT];
  logic [7:0] resp_v   [NDUT];
  logic [7:0] seed_v   [NDUT];
  logic [7:0] golden_v [NDUT];
  logic [7:0] sig_o    [NDUT];
  logic       busy_v   [NDUT];
  logic       done_v   [NDUT];
  logic       pass_v   [NDUT];
  logic       fail_v   [NDUT];

  logic [2:0] sig_a;
  logic [7:0] sig_b, sig_c, sig_d;
  assign sig_o[0] = {5'b0, sig_a};
  assign sig_o[1] = sig_b;
  assign sig_o[2] = sig_c;
  assign sig_o[3] = sig_d;

  bist_ora_misr #(.WIDTH(3), .CHANNELS(1), .POLY(3'b011), .NUM_PATTERNS(3)) u_a (
    .clk(clk), .rst(rst_v[0]), .init(init_v[0]), .en(en_v[0]), .resp(resp_v[0][0:0]),
    .seed(seed_v[0][2:0]), .golden(golden_v[0][2:0]), .sig(sig_a),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]));

  bist_ora_misr #(.WIDTH(8), .CHANNELS(1), .POLY(8'h1D), .NUM_PATTERNS(16)) u_b (
    .clk(clk), .rst(rst_v[1]), .init(init_v[1]), .en(en_v[1]), .resp(resp_v[1][0:0]),
    .seed(seed_v[1]), .golden(golden_v[1]), .sig(sig_b),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]));

  bist_ora_misr #(.WIDTH(8), .CHANNELS(4), .POLY(8'h1D), .NUM_PATTERNS(16)) u_c (
    .clk(clk), .rst(rst_v[2]), .init(init_v[2]), .en(en_v[2]), .resp(resp_v[2][3:0]),
    .seed(seed_v[2]), .golden(golden_v[2]), .sig(sig_c),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]));

  bist_ora_misr #(.WIDTH(8), .CHANNELS(1), .POLY(8'h1D), .NUM_PATTERNS(1)) u_d (
    .clk(clk), .rst(rst_v[3]), .init(init_v[3]), .en(en_v[3]), .resp(resp_v[3][0:0]),
    .seed(seed_v[3]), .golden(golden_v[3]), .sig(sig_d),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .fail(fail_v[3]));

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0=IDLE 1=COMPACT 2=CHECK 3=DONE
  int         m_st   [NDUT];
  int         m_cnt  [NDUT];
  logic [7:0] m_sig  [NDUT];
  logic       m_pass [NDUT];
  logic       m_fail [NDUT];

  function automatic logic [7:0] wmask(input int d);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < W_P[d]; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] mnext(input int d, input logic [7:0] s, input logic [7:0] r);
    logic [7:0] n;
    logic       fb;
    n  = '0;
    fb = s[W_P[d]-1];
    for (int i = 0; i < W_P[d]; i++) begin
      n[i] = PL_P[d][i] & fb;
      if (i > 0)       n[i] = n[i] ^ s[i-1];
      if (i < CH_P[d]) n[i] = n[i] ^ r[i];
    end
    return n;
  endfunction

  task automatic model(input int d, input bit r, input bit ini, input bit e, input logic [7:0] rs);
    if (r) begin
      m_st[d] = 0; m_sig[d] = '0; m_cnt[d] = 0; m_pass[d] = 0; m_fail[d] = 0;
    end else if (ini) begin
      m_st[d] = 1; m_sig[d] = seed_v[d] & wmask(d); m_cnt[d] = 0; m_pass[d] = 0; m_fail[d] = 0;
    end else if (m_st[d] == 1) begin
      if (e) begin
        m_sig[d] = mnext(d, m_sig[d], rs);
        if (m_cnt[d] == NP_P[d] - 1) m_st[d] = 2;
        m_cnt[d]++;
      end
    end else if (m_st[d] == 2) begin
      m_pass[d] = (m_sig[d] == (golden_v[d] & wmask(d)));
      m_fail[d] = !m_pass[d];
      m_st[d]   = 3;
    end
  endtask

  typedef struct {
    int         d;
    logic [7:0] sig;
    logic       busy, done, pass, fail;
  } exp_t;
  exp_t sb[$];

  task automatic step(input int d, input bit r, input bit ini, input bit e, input logic [7:0] rs);
    exp_t x;
    rst_v[d] = r; init_v[d] = ini; en_v[d] = e; resp_v[d] = rs;
    model(d, r, ini, e, rs);
    x.d = d; x.sig = m_sig[d];
    x.busy = (m_st[d] == 1) || (m_st[d] == 2);
    x.done = (m_st[d] == 3);
    x.pass = m_pass[d]; x.fail = m_fail[d];
    sb.push_back(x);
    @(posedge clk); #1;
    x = sb.pop_front();
    chk($sformatf("d%0d.sig",  x.d), 32'(sig_o[x.d]),  32'(x.sig));
    chk($sformatf("d%0d.busy", x.d), 32'(busy_v[x.d]), 32'(x.busy));
    chk($sformatf("d%0d.done", x.d), 32'(done_v[x.d]), 32'(x.done));
    chk($sformatf("d%0d.pass", x.d), 32'(pass_v[x.d]), 32'(x.pass));
    chk($sformatf("d%0d.fail", x.d), 32'(fail_v[x.d]), 32'(x.fail));
    rst_v[d] = 1'b0; init_v[d] = 1'b0; en_v[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst_v[d] = 1'b1; init_v[d] = 1'b0; en_v[d] = 1'b0;
      resp_v[d] = '0; seed_v[d] = '0; golden_v[d] = '0;
    end
    #2;
    // Reset every instance, then release the others while one is exercised.
    for (int d = 0; d < NDUT; d++) step(d, 1'b1, 1'b0, 1'b0, 8'h00);

    // Legacy equivalence: 3-bit, resp 1,0,1 -> 001,010,101, pass
    seed_v[0] = 8'h0; golden_v[0] = 8'h5;
    step(0, 0, 1, 0, 8'h0);
    step(0, 0, 0, 1, 8'h1); chk("legacy.s1", 32'(sig_o[0]), 32'h1);
    step(0, 0, 0, 1, 8'h0); chk("legacy.s2", 32'(sig_o[0]), 32'h2);
    step(0, 0, 0, 1, 8'h1); chk("legacy.s3", 32'(sig_o[0]), 32'h5);
    chk("legacy.check_busy", 32'(busy_v[0]), 32'h1);
    step(0, 0, 0, 0, 8'h0);
    chk("legacy.pass", 32'(pass_v[0]), 32'h1);
    chk("legacy.fail", 32'(fail_v[0]), 32'h0);

    // Feedback path: seed 100, resp 0 -> 011; wrong golden -> fail
    seed_v[0] = 8'h4; golden_v[0] = 8'h0;
    step(0, 0, 1, 0, 8'h0);
    step(0, 0, 0, 1, 8'h0); chk("fb.sig", 32'(sig_o[0]), 32'h3);
    step(0, 0, 0, 1, 8'h0);
    step(0, 0, 0, 1, 8'h0);
    step(0, 0, 0, 0, 8'h0);
    chk("fb.fail", 32'(fail_v[0]), 32'h1);

    // Reset while DONE, then en ignored
    step(0, 1, 0, 0, 8'h0);
    chk("rst_done.sig", 32'(sig_o[0]), 32'h0);
    step(0, 0, 0, 1, 8'h1);
    step(0, 0, 0, 1, 8'h1);

    // Stall gaps on the default config; golden set to the bench's prediction
    seed_v[1] = 8'h5A;
    step(1, 0, 1, 0, 8'h0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 1, 8'($urandom_range(0, 1)));
      if (i % 3 == 1) begin
        step(1, 0, 0, 0, 8'h1);
        step(1, 0, 0, 0, 8'h1);
      end
    end
    golden_v[1] = m_sig[1];
    step(1, 0, 0, 0, 8'h0);
    chk("stall.pass", 32'(pass_v[1]), 32'h1);
    step(1, 0, 0, 1, 8'h1);  // en ignored in DONE

    // init and en together: seed loaded, resp not compacted
    seed_v[1] = 8'hC3;
    step(1, 0, 1, 1, 8'h1);
    chk("prio.sig", 32'(sig_o[1]), 32'hC3);
    step(1, 0, 0, 1, 8'h1);
    step(1, 0, 0, 1, 8'h0);
    // Mid-run init discards partial signature
    seed_v[1] = 8'h11;
    step(1, 0, 1, 0, 8'h0);
    chk("reinit.sig", 32'(sig_o[1]), 32'h11);
    step(1, 0, 0, 1, 8'h1);
    // Mid-run reset
    step(1, 1, 0, 0, 8'h0);
    chk("rst_mid.sig", 32'(sig_o[1]), 32'h0);
    chk("rst_mid.busy", 32'(busy_v[1]), 32'h0);
    step(1, 0, 0, 1, 8'h1);
    step(1, 0, 0, 1, 8'h1);

    // Multi-channel: 0F then 1E, then finish the run with random responses
    seed_v[2] = 8'h00; golden_v[2] = 8'($urandom);
    step(2, 0, 1, 0, 8'h0);
    step(2, 0, 0, 1, 8'h0F); chk("mc.s1", 32'(sig_o[2]), 32'h0F);
    step(2, 0, 0, 1, 8'h00); chk("mc.s2", 32'(sig_o[2]), 32'h1E);
    for (int i = 0; i < 14; i++) step(2, 0, 0, 1, 8'($urandom_range(0, 15)));
    step(2, 0, 0, 0, 8'h0);

    // Single pattern: 80 with resp 1 -> 1C, straight to CHECK
    seed_v[3] = 8'h80; golden_v[3] = 8'h1C;
    step(3, 0, 1, 0, 8'h0);
    step(3, 0, 0, 1, 8'h1);
    chk("np1.sig", 32'(sig_o[3]), 32'h1C);
    chk("np1.busy", 32'(busy_v[3]), 32'h1);
    step(3, 0, 0, 0, 8'h0);
    chk("np1.done", 32'(done_v[3]), 32'h1);
    chk("np1.pass", 32'(pass_v[3]), 32'h1);
    golden_v[3] = 8'h00;
    step(3, 0, 1, 0, 8'h0);
    step(3, 0, 0, 1, 8'h1);
    step(3, 0, 0, 0, 8'h0);
    chk("np1.fail", 32'(fail_v[3]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
